// File: rtl/async_reset_pkg.sv
// -----------------------------------------------------------------------------
// async_reset_pkg
//   Shared defaults for the async-reset delay line and its reset synchroniser.
//
//   DEFAULT_WIDTH        data width of a pipeline beat
//   DEFAULT_DEPTH        number of pipeline stages (latency in enabled cycles)
//   DEFAULT_SYNC_STAGES  flop count of the reset release synchroniser
//   occ_width()          bit width needed to count 0..depth valid stages
// -----------------------------------------------------------------------------
package async_reset_pkg;

    localparam int DEFAULT_WIDTH       = 32'd8;
    localparam int DEFAULT_DEPTH       = 32'd4;
    localparam int DEFAULT_SYNC_STAGES = 32'd2;

    // Width of an occupancy counter able to hold every value 0..depth.
    // A depth below one is illegal; it is mapped to a one-bit counter so the
    // declaration never collapses to a zero-width vector.
    function automatic int occ_width(input int depth);
        int w;
        if (depth < 32'sd1) begin
            w = 32'sd1;
        end else begin
            w = $clog2(depth + 32'sd1);
        end
        return w;
    endfunction

endpackage : async_reset_pkg

// File: rtl/async_reset_sync.sv
// -----------------------------------------------------------------------------
// async_reset_sync
//   Reset synchroniser: reset is asserted asynchronously and released
//   synchronously. A chain of SYNC_STAGES flops is fed with a constant one and
//   cleared by reset_n, so rst_sync_n rises on the SYNC_STAGES-th rising clk
//   edge after reset_n goes high. Reusable by any block that must share the
//   same release timing.
//
//   Ports
//     clk         in   clock, rising edge
//     reset_n     in   asynchronous active-low reset
//     rst_sync_n  out  synchronised active-low reset
// -----------------------------------------------------------------------------
module async_reset_sync
    import async_reset_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset_n,
    output logic rst_sync_n
);

    // The chain must have at least two flops to give the release edge a full
    // cycle to settle before it is used.
    localparam int STAGES = (SYNC_STAGES < 32'sd2) ? 32'sd2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_r;

    // Shift a constant one through the chain; reset empties it at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_r[STAGES-1];

endmodule : async_reset_sync

// File: rtl/async_reset_pipe.sv
// -----------------------------------------------------------------------------
// async_reset_pipe
//   Multi-stage registered delay line carrying WIDTH-bit data plus a valid
//   qualifier through DEPTH stages. Reset is asserted asynchronously by
//   reset_n and released through an internal synchroniser whose output is
//   exported for neighbouring blocks. Supports stall (en), synchronous flush
//   and tracks how many stages hold a valid beat.
//
//   Parameters
//     WIDTH        data width (>=1)
//     DEPTH        stage count, latency in enabled cycles (>=1)
//     SYNC_STAGES  reset synchroniser length (>=2)
//     RESET_VAL    data value of every stage on reset, flush or bubble
//
//   Ports
//     clk         in   clock, rising edge
//     reset_n     in   asynchronous active-low reset
//     en          in   advance enable, 0 = all stages hold
//     flush       in   synchronous clear of all stages (beats that cycle drop)
//     in_valid    in   input beat qualifier
//     in_data     in   input data
//     out_valid   out  valid of the last stage
//     out_data    out  data of the last stage
//     occupancy   out  number of stages holding a valid beat
//     busy        out  occupancy != 0 (registered)
//     rst_sync_n  out  synchronised reset (async assert, sync release)
// -----------------------------------------------------------------------------
module async_reset_pipe
    import async_reset_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter int               DEPTH       = DEFAULT_DEPTH,
    parameter int               SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       busy,
    output logic                       rst_sync_n
);

    localparam int OCC_W = occ_width(DEPTH);

    // One pipeline slot: qualifier plus payload.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    localparam stage_t STAGE_RESET = '{valid: 1'b0, data: RESET_VAL};

    logic             rst_sync_s;
    stage_t           stage_r     [DEPTH];
    stage_t           stage_nxt_s [DEPTH];
    logic [OCC_W-1:0] occ_r;
    logic [OCC_W-1:0] occ_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;

    // -------------------------------------------------------------------------
    // Reset release synchroniser, shared with the outside world.
    // -------------------------------------------------------------------------
    async_reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .rst_sync_n (rst_sync_s)
    );

    // Next-state of every stage and of the occupancy counter.
    // While the synchronised reset is still low the pipeline stays at its reset
    // image, so a beat presented during release can never leak in. Otherwise
    // flush beats en, and en beats hold.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_nxt_s[k] = stage_r[k];
        end
        occ_nxt_s = occ_r;

        if (!rst_sync_s) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_nxt_s[k] = STAGE_RESET;
            end
            occ_nxt_s = {OCC_W{1'b0}};
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_nxt_s[k] = STAGE_RESET;
            end
            occ_nxt_s = {OCC_W{1'b0}};
        end else if (en) begin
            // Bubbles carry RESET_VAL so stale payloads never propagate.
            stage_nxt_s[0].valid = in_valid;
            stage_nxt_s[0].data  = in_valid ? in_data : RESET_VAL;
            for (int k = 1; k < DEPTH; k++) begin
                stage_nxt_s[k] = stage_r[k-1];
            end
            // Push and pop in the same cycle cancel, so a full pipeline stays
            // full; the last stage is popped only when it leaves, which keeps
            // the count bounded by DEPTH.
            occ_nxt_s = occ_r + OCC_W'(in_valid) - OCC_W'(stage_r[DEPTH-1].valid);
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_nxt_s[k] = stage_r[k];
            end
            occ_nxt_s = occ_r;
        end

        busy_nxt_s = (occ_nxt_s != {OCC_W{1'b0}});
    end

    // Pipeline, occupancy and busy registers; reset_n clears them immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k] <= STAGE_RESET;
            end
            occ_r  <= {OCC_W{1'b0}};
            busy_r <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k] <= stage_nxt_s[k];
            end
            occ_r  <= occ_nxt_s;
            busy_r <= busy_nxt_s;
        end
    end

    // All outputs come straight from registers.
    assign out_valid  = stage_r[DEPTH-1].valid;
    assign out_data   = stage_r[DEPTH-1].data;
    assign occupancy  = occ_r;
    assign busy       = busy_r;
    assign rst_sync_n = rst_sync_s;

endmodule : async_reset_pipe
